// File: rtl/button_debounce_if.sv
// Button conditioning bundle: raw pins and sticky-clear in, clean level/pulse/sticky/read-data out.
interface button_debounce_if #(parameter int N_BTN = 5);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] press_clr;
    logic [31:0]      btn_rdata;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] btn_fall;
    logic [N_BTN-1:0] btn_pressed;

    modport master (
        output btn_raw, press_clr,
        input  btn_rdata, btn_level, btn_rise, btn_fall, btn_pressed
    );

    modport slave (
        input  btn_raw, press_clr,
        output btn_rdata, btn_level, btn_rise, btn_fall, btn_pressed
    );
endinterface

// File: rtl/button_debounce.sv
// Per-button 2-flop synchronizer + stability-count debounce FSM, with rise/fall pulses,
// sticky pressed flags and a zero-extended 32-bit level word for the bridge.
module button_debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic clr,
    output logic level,
    output logic rise,
    output logic fall,
    output logic pressed
);
    typedef enum logic [1:0] {IDLE_LO, DB_HI, IDLE_HI, DB_LO} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               IMMEDIATE = (DEBOUNCE_CYCLES == 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             s1, s;
    logic             rise_nxt, fall_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= 1'b0;
            s       <= 1'b0;
            state   <= IDLE_LO;
            cnt     <= '0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            pressed <= 1'b0;
        end else begin
            s1      <= raw;
            s       <= s1;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rise    <= rise_nxt;
            fall    <= fall_nxt;
            // a rise in the same cycle as a clear keeps the flag set
            pressed <= rise | (pressed & ~clr);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            IDLE_LO: begin
                cnt_nxt = '0;
                if (s) begin
                    if (IMMEDIATE) begin
                        state_nxt = IDLE_HI;
                        rise_nxt  = 1'b1;
                    end else begin
                        state_nxt = DB_HI;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            DB_HI: begin
                if (!s) begin
                    state_nxt = IDLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_HI;
                    cnt_nxt   = '0;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            IDLE_HI: begin
                cnt_nxt = '0;
                if (!s) begin
                    if (IMMEDIATE) begin
                        state_nxt = IDLE_LO;
                        fall_nxt  = 1'b1;
                    end else begin
                        state_nxt = DB_LO;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            DB_LO: begin
                if (s) begin
                    state_nxt = IDLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_LO;
                    cnt_nxt   = '0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    // level is 1 while accepted-high, including while a falling edge is still being qualified
    assign level = (state == IDLE_HI) || (state == DB_LO);
endmodule

module button_debounce #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                clk,
    input  logic                rst,
    button_debounce_if.slave    bus
);
    genvar i;
    generate
        for (i = 0; i < N_BTN; i++) begin : g_lane
            button_debounce_lane #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_lane (
                .clk    (clk),
                .rst    (rst),
                .raw    (bus.btn_raw[i]),
                .clr    (bus.press_clr[i]),
                .level  (bus.btn_level[i]),
                .rise   (bus.btn_rise[i]),
                .fall   (bus.btn_fall[i]),
                .pressed(bus.btn_pressed[i])
            );
        end
    endgenerate

    always_comb begin
        bus.btn_rdata              = '0;
        bus.btn_rdata[N_BTN-1:0]   = bus.btn_level;
    end
endmodule

// File: tb/tb_button_debounce.sv
// Randomized bench: a run-length reference model predicts every cycle's outputs into a queue
// that an independent monitor drains and compares.
module tb_button_debounce;
    localparam int N = 5;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    button_debounce_if #(.N_BTN(N)) bus();

    button_debounce #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] pressed;
        logic [31:0]  rdata;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference: a button's level flips once the synchronized pin has disagreed with it
    // for D consecutive sampling edges; the pin reaches the decision logic two edges late.
    logic [N-1:0] m_s1, m_s, m_level, m_rise, m_fall, m_pressed;
    int           run [N];

    always @(posedge clk) begin
        obs_t         e;
        logic [N-1:0] nr, nf;
        nr = '0;
        nf = '0;
        if (rst) begin
            m_s1 = '0; m_s = '0; m_level = '0; m_rise = '0; m_fall = '0; m_pressed = '0;
            for (int i = 0; i < N; i++) run[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_s[i] != m_level[i]) run[i] = run[i] + 1;
                else                      run[i] = 0;
                if (run[i] == D) begin
                    if (m_level[i]) nf[i] = 1'b1;
                    else            nr[i] = 1'b1;
                    m_level[i] = ~m_level[i];
                    run[i]     = 0;
                end
            end
            m_pressed = m_rise | (m_pressed & ~bus.press_clr);
            m_rise    = nr;
            m_fall    = nf;
            m_s       = m_s1;
            m_s1      = bus.btn_raw;
        end
        e.level   = m_level;
        e.rise    = m_rise;
        e.fall    = m_fall;
        e.pressed = m_pressed;
        e.rdata   = 32'(m_level);
        exp_q.push_back(e);
    end

    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            a = '{bus.btn_level, bus.btn_rise, bus.btn_fall, bus.btn_pressed, bus.btn_rdata};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty t=%0t no expected entry for observed outputs", $time);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    failures++;
                    $display("FAIL cycle_outputs t=%0t got lvl=%b rise=%b fall=%b prs=%b rd=%h exp lvl=%b rise=%b fall=%b prs=%b rd=%h",
                             $time, a.level, a.rise, a.fall, a.pressed, a.rdata,
                             e.level, e.rise, e.fall, e.pressed, e.rdata);
                end
            end
        end
    end

    task automatic hold(input logic [N-1:0] raw, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            bus.btn_raw   = raw;
            bus.press_clr = '0;
        end
    endtask

    initial begin
        bus.btn_raw   = '0;
        bus.press_clr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // all buttons at once, then release, then a short bounce on button 1
        hold(5'b11111, 10);
        hold(5'b00000, 10);
        hold(5'b00010, 3);
        hold(5'b00000, 8);
        hold(5'b00100, 2);
        hold(5'b00000, 1);
        hold(5'b00100, 10);
        hold(5'b00000, 10);

        // alternating bouncy / calm random phases with random sticky clears
        for (int ph = 0; ph < 8; ph++) begin
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, (ph % 2) ? 12 : 3) == 0)
                        bus.btn_raw[i] = ~bus.btn_raw[i];
                bus.press_clr = N'($urandom & $urandom);
            end
        end

        // reset while button 4 is mid-qualification
        hold(5'b00000, 12);
        hold(5'b10000, 4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.btn_level, bus.btn_rise, bus.btn_fall, bus.btn_pressed} !== '0 || bus.btn_rdata !== 32'h0) begin
            failures++;
            $display("FAIL async_reset got lvl=%b rise=%b fall=%b prs=%b rd=%h exp all zero",
                     bus.btn_level, bus.btn_rise, bus.btn_fall, bus.btn_pressed, bus.btn_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        hold(5'b10000, 12);
        hold(5'b00000, 10);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Conditions the raw push-button pins before they reach the bus bridge's button read port.
- Per button: 2-flop synchronizer, then a debounce FSM with a stability counter.
- Produces a clean level word, formatted as the 32-bit button read data, plus one-cycle rise/fall pulses.
- Keeps a sticky "pressed" flag per button that software clears through a clear strobe.
- Sits between the board button pins and the bridge, clocked by the CPU clock domain.

Parameters:
- N_BTN, 5, number of buttons; 1..32.
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronized cycles needed to accept a change; >= 1.
- CNT_W, 16, counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.

Ports:
- clk, input, 1: clock, rising-edge.
- rst, input, 1: reset, asynchronous, active-high.
- btn_raw, input, N_BTN: raw asynchronous button pins, 1 = pressed.
- press_clr, input, N_BTN: per-button sticky clear strobe, synchronous to clk.
- btn_rdata, output, 32: {(32-N_BTN) zeros, btn_level}; feeds the bridge's button read data.
- btn_level, output, N_BTN: debounced level.
- btn_rise, output, N_BTN: 1-cycle pulse on accepted 0->1 transition.
- btn_fall, output, N_BTN: 1-cycle pulse on accepted 1->0 transition.
- btn_pressed, output, N_BTN: sticky flag, set by a rise and cleared by press_clr.

Behaviour:
- Reset (async assert, takes effect immediately, no clock needed):
  - sync stages = 0, counters = 0, FSM = IDLE_LO.
  - btn_level, btn_rise, btn_fall, btn_pressed = 0; btn_rdata = 32'h0.
  - Release is synchronous to the next clk edge.
- Synchronizer: s1 <= btn_raw[i]; s <= s1. All logic below uses s only.
- Per-button FSM states, one per button, all buttons independent:
  - IDLE_LO: level 0, cnt = 0. If s == 1: DEBOUNCE_CYCLES == 1 -> accept immediately; else go to DB_HI with cnt = 1.
  - DB_HI: if s == 0, go to IDLE_LO with cnt = 0 (bounce rejected). Else if cnt == DEBOUNCE_CYCLES-1, go to IDLE_HI, level <= 1, rise pulse, cnt = 0. Else cnt++.
  - IDLE_HI and DB_LO: mirror images with polarity swapped; acceptance produces a fall pulse.
- Latency: count the first clk edge that samples the new raw value as edge 1. btn_level changes at edge DEBOUNCE_CYCLES+2, provided btn_raw is held stable throughout.
  - Any glitch back to the old level before acceptance restarts the full count.
- Pulses:
  - btn_rise/btn_fall are registered and asserted in the same cycle that btn_level changes.
  - Each pulse lasts exactly 1 cycle.
  - Rise and fall of one button are never asserted in the same cycle.
- Sticky flag: btn_pressed[i] is set on btn_rise[i] and cleared on press_clr[i].
  - If both occur in the same cycle, set wins and the flag stays 1.
  - press_clr while the flag is 0 has no effect.
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps; no saturation logic beyond that.
- btn_rdata is combinational from btn_level: bits [31:N_BTN] = 0.
- Reset mid-debounce discards the partial count. After release, a still-pressed button is re-debounced from IDLE_LO and produces a fresh rise pulse.
- Simultaneous changes on several buttons are handled fully in parallel; counters are not shared.

Test Plan:
- DEBOUNCE_CYCLES=4, N_BTN=5. btn_raw=5'b00001 held from edge 1 -> btn_level[0]=1 and btn_rise[0]=1 for one cycle at edge 6; btn_rdata=32'h1; btn_pressed[0]=1.
- btn_raw[1] pulses high for 3 cycles then returns low -> btn_level[1] stays 0; no rise pulse; btn_pressed[1]=0.
- btn_raw[2] high for 2 cycles, low 1, high 10 -> btn_level[2] rises exactly 6 edges after the final rising sample; a single rise pulse.
- Button 0 accepted high, then btn_raw[0]=0 held -> btn_fall[0] 1-cycle pulse 6 edges later; btn_level=0; btn_pressed[0] stays 1 until press_clr[0]=1 for 1 cycle, then 0 on the next edge.
- press_clr[3] asserted in the same cycle as btn_rise[3] -> btn_pressed[3]=1 afterwards.
- rst asserted while button 4 is mid-count with btn_raw[4] held 1 -> all outputs 0 immediately. After release, rise on button 4 occurs 6 edges later (counting edges after release).
- btn_raw=5'b11111 simultaneously -> all five levels and rise pulses assert on the same edge; btn_rdata=32'h1F.
